// File: rtl/dcache_bus_master_pkg.sv
// Shared TileLink-UL constants, source IDs, FSM encoding and A-channel payload
// type for the Dcache bus master.
package dcache_bus_master_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;
  localparam int unsigned SRC_W  = 5;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned SIZE_W = 4;
  localparam int unsigned WDOG_W = 16;

  // TileLink-UL opcodes
  localparam logic [OP_W-1:0] A_PUTFULL = 3'd0;
  localparam logic [OP_W-1:0] A_GET     = 3'd4;
  localparam logic [OP_W-1:0] D_ACK     = 3'd0;
  localparam logic [OP_W-1:0] D_ACKDATA = 3'd1;

  // Single 32-bit word: log2(4 bytes)
  localparam logic [SIZE_W-1:0] TL_SIZE_WORD = 4'd2;
  localparam logic [MASK_W-1:0] FULL_MASK    = 4'hF;

  // Master source IDs
  localparam logic [SRC_W-1:0] SRC_DCACHE = 5'b00001;
  localparam logic [SRC_W-1:0] SRC_ICACHE = 5'b00010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND_A = 2'd1,
    ST_WAIT_D = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Variable part of an A-channel beat
  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
  } tl_a_req_t;

endpackage

// File: rtl/bus_resp_watchdog.sv
// Response watchdog: 16-bit saturating cycle counter with synchronous clear
// and count enable. expire_c flags the enabled cycle in which the counter
// reaches TIMEOUT_CYCLES.
// Ports: clk, rst_n, clr (zero counter), en (count this cycle), expire_c.
module bus_resp_watchdog
  import dcache_bus_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  logic [WDOG_W-1:0] count_q;

  // Saturating counter; clear has priority over enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && (count_q != {WDOG_W{1'b1}})) begin
      count_q <= count_q + WDOG_W'(1);
    end
  end

  // Expiry fires on the cycle whose increment would reach the limit
  assign expire_c = en &&
                    (({1'b0, count_q} + 17'd1) >= 17'(TIMEOUT_CYCLES));

endmodule

// File: rtl/dcache_bus_master.sv
// Dcache bus master: turns single-word cache requests into TileLink-UL
// Get/PutFullData beats, tracks one outstanding transaction, and returns the
// AccessAck/AccessAckData result (or a watchdog timeout error) to the cache.
// Ports: req_* cache request/handshake; resp_* one-cycle completion;
// a_* TileLink A channel (master out); d_* TileLink D channel (slave in).
module dcache_bus_master
  import dcache_bus_master_pkg::*;
#(
  parameter logic [SRC_W-1:0] SOURCE_ID      = SRC_DCACHE,
  parameter int unsigned      TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_mask,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [OP_W-1:0]   a_opcode,
  output logic [2:0]        a_param,
  output logic [SIZE_W-1:0] a_size,
  output logic [SRC_W-1:0]  a_source,
  output logic [ADDR_W-1:0] a_address,
  output logic [MASK_W-1:0] a_mask,
  output logic [DATA_W-1:0] a_data,
  output logic              a_corrupt,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [OP_W-1:0]   d_opcode,
  input  logic [SRC_W-1:0]  d_source,
  input  logic [DATA_W-1:0] d_data,
  input  logic              d_denied,
  input  logic              d_corrupt
);

  state_e            state_q, state_n;
  tl_a_req_t         a_q, a_n;
  logic              we_q, we_n;
  logic              err_n;
  logic [DATA_W-1:0] rdata_n;
  logic              wd_clr, wd_en, wd_expire_c;

  bus_resp_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .expire_c(wd_expire_c)
  );

  // State, captured request and registered outputs (decoded from next state)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      we_q       <= 1'b0;
      req_ready  <= 1'b1;
      a_valid    <= 1'b0;
      d_ready    <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state_q    <= state_n;
      a_q        <= a_n;
      we_q       <= we_n;
      req_ready  <= (state_n == ST_IDLE);
      a_valid    <= (state_n == ST_SEND_A);
      d_ready    <= (state_n == ST_WAIT_D);
      resp_valid <= (state_n == ST_RESP);
      resp_err   <= err_n;
      resp_rdata <= rdata_n;
    end
  end

  // Next-state, capture and completion result
  always_comb begin
    state_n = state_q;
    a_n     = a_q;
    we_n    = we_q;
    err_n   = 1'b0;
    rdata_n = '0;
    wd_clr  = 1'b0;
    wd_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          a_n.address = req_addr;
          a_n.data    = req_we ? req_wdata : '0;
          a_n.opcode  = req_we ? A_PUTFULL : A_GET;
          we_n        = req_we;
          // Unaligned or partial-word requests fail without touching the bus
          if ((req_addr[1:0] != 2'b00) || (req_mask != FULL_MASK)) begin
            state_n = ST_RESP;
            err_n   = 1'b1;
          end else begin
            state_n = ST_SEND_A;
          end
        end
      end
      ST_SEND_A: begin
        if (a_ready) begin
          wd_clr  = 1'b1;
          state_n = ST_WAIT_D;
        end
      end
      ST_WAIT_D: begin
        wd_en = 1'b1;
        // A matching beat beats a simultaneous watchdog expiry
        if (d_valid && (d_source == SOURCE_ID)) begin
          state_n = ST_RESP;
          err_n   = d_denied || d_corrupt ||
                    (d_opcode != (we_q ? D_ACK : D_ACKDATA));
          rdata_n = (!we_q && !err_n) ? d_data : '0;
        end else if (wd_expire_c) begin
          state_n = ST_RESP;
          err_n   = 1'b1;
        end
      end
      ST_RESP: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign a_opcode  = a_q.opcode;
  assign a_address = a_q.address;
  assign a_data    = a_q.data;
  assign a_param   = 3'd0;
  assign a_size    = TL_SIZE_WORD;
  assign a_source  = SOURCE_ID;
  assign a_mask    = FULL_MASK;
  assign a_corrupt = 1'b0;

endmodule

// File: tb/tb_dcache_bus_master.sv
// Directed bench for dcache_bus_master with a response scoreboard.
module tb_dcache_bus_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic        req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_mask;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        a_valid, a_ready, a_corrupt;
  logic [2:0]  a_opcode, a_param;
  logic [3:0]  a_size, a_mask;
  logic [4:0]  a_source;
  logic [31:0] a_address, a_data;
  logic        d_valid, d_ready, d_denied, d_corrupt;
  logic [2:0]  d_opcode;
  logic [4:0]  d_source;
  logic [31:0] d_data;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   req_cyc = 0;
  int   a_valid_cnt = 0;
  int   lat;
  int   av_before;

  dcache_bus_master #(
    .SOURCE_ID     (5'b00001),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_mask  (req_mask),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_opcode  (a_opcode),
    .a_param   (a_param),
    .a_size    (a_size),
    .a_source  (a_source),
    .a_address (a_address),
    .a_mask    (a_mask),
    .a_data    (a_data),
    .a_corrupt (a_corrupt),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .d_opcode  (d_opcode),
    .d_source  (d_source),
    .d_data    (d_data),
    .d_denied  (d_denied),
    .d_corrupt (d_corrupt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (a_valid) a_valid_cnt <= a_valid_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every completion must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
  end

  task automatic push_exp(input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    sb.push_back(e);
  endtask

  // Called just after a posedge; presents the request for one cycle
  task automatic start_req(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_mask  = mask;
    req_cyc   = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int l);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        l = cyc - req_cyc;
        return;
      end
    end
    l = -1;
    chk("resp_timeout", 32'(resp_valid), 32'd1);
  endtask

  task automatic set_d(input logic v, input logic [4:0] src, input logic [2:0] op,
                       input logic [31:0] data, input logic den);
    d_valid  = v;
    d_source = src;
    d_opcode = op;
    d_data   = data;
    d_denied = den;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_mask = 4'hF;
    a_ready = 1'b0; d_corrupt = 1'b0;
    set_d(1'b0, 5'd0, 3'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_d_ready", 32'(d_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_a_consts", {a_size, a_mask, 3'(a_param), a_source, a_corrupt}, {4'd2, 4'hF, 3'd0, 5'd1, 1'b0});
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Read on an ideal bus
    a_ready = 1'b1;
    set_d(1'b1, 5'd1, 3'd1, 32'hDEAD_BEEF, 1'b0);
    push_exp(32'hDEAD_BEEF, 1'b0);
    start_req(1'b0, 32'h0000_1000, 32'h0, 4'hF);
    @(negedge clk);
    chk("rd_a_valid", 32'(a_valid), 32'd1);
    chk("rd_a_opcode", 32'(a_opcode), 32'd4);
    chk("rd_a_address", a_address, 32'h0000_1000);
    chk("rd_a_data", a_data, 32'd0);
    wait_resp(lat);
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_req_ready_in_resp", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("rd_resp_one_cycle", 32'(resp_valid), 32'd0);
    chk("rd_back_to_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;

    // Write with A back-pressure
    a_ready = 1'b0;
    set_d(1'b0, 5'd1, 3'd0, 32'hFFFF_FFFF, 1'b0);
    push_exp(32'd0, 1'b0);
    start_req(1'b1, 32'h0000_2004, 32'h1234_5678, 4'hF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wr_a_valid", 32'(a_valid), 32'd1);
      chk("wr_a_opcode", 32'(a_opcode), 32'd0);
      chk("wr_a_address", a_address, 32'h0000_2004);
      chk("wr_a_data", a_data, 32'h1234_5678);
      @(posedge clk);
      #1;
    end
    a_ready = 1'b1;
    @(posedge clk);
    #1 a_ready = 1'b0;
    set_d(1'b1, 5'd1, 3'd0, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    chk("wr_d_ready", 32'(d_ready), 32'd1);
    chk("wr_a_valid_drop", 32'(a_valid), 32'd0);
    wait_resp(lat);
    chk("wr_latency", 32'(lat), 32'd7);
    @(posedge clk);
    #1 set_d(1'b0, 5'd0, 3'd0, 32'd0, 1'b0);

    // Foreign-source beat is dropped, own beat completes
    a_ready = 1'b1;
    push_exp(32'hA5A5_A5A5, 1'b0);
    start_req(1'b0, 32'h0000_3000, 32'h0, 4'hF);
    @(posedge clk);
    #1 set_d(1'b1, 5'b00010, 3'd1, 32'h1111_1111, 1'b0);
    @(negedge clk);
    chk("fs_d_ready", 32'(d_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("fs_still_waiting", 32'(d_ready), 32'd1);
    chk("fs_no_resp", 32'(resp_valid), 32'd0);
    set_d(1'b1, 5'b00001, 3'd1, 32'hA5A5_A5A5, 1'b0);
    @(posedge clk);
    #1 set_d(1'b0, 5'd0, 3'd0, 32'd0, 1'b0);
    wait_resp(lat);
    chk("fs_latency", 32'(lat), 32'd4);
    @(posedge clk);
    #1;

    // Denied access
    set_d(1'b1, 5'd1, 3'd1, 32'h0000_1234, 1'b1);
    push_exp(32'd0, 1'b1);
    start_req(1'b0, 32'h0000_4000, 32'h0, 4'hF);
    wait_resp(lat);
    chk("den_latency", 32'(lat), 32'd3);
    @(posedge clk);
    #1;

    // Wrong D opcode for a Get
    set_d(1'b1, 5'd1, 3'd0, 32'h0000_5678, 1'b0);
    push_exp(32'd0, 1'b1);
    start_req(1'b0, 32'h0000_5000, 32'h0, 4'hF);
    wait_resp(lat);
    chk("op_latency", 32'(lat), 32'd3);
    @(posedge clk);
    #1 set_d(1'b0, 5'd0, 3'd0, 32'd0, 1'b0);

    // Misaligned address: error with no bus beat
    av_before = a_valid_cnt;
    push_exp(32'd0, 1'b1);
    start_req(1'b0, 32'h0000_0003, 32'h0, 4'hF);
    wait_resp(lat);
    chk("mis_latency", 32'(lat), 32'd1);
    chk("mis_no_a_valid", 32'(a_valid_cnt - av_before), 32'd0);
    @(posedge clk);
    #1;

    // Partial mask: error with no bus beat
    av_before = a_valid_cnt;
    push_exp(32'd0, 1'b1);
    start_req(1'b1, 32'h0000_6000, 32'hBBBB_BBBB, 4'h3);
    wait_resp(lat);
    chk("msk_latency", 32'(lat), 32'd1);
    chk("msk_no_a_valid", 32'(a_valid_cnt - av_before), 32'd0);
    @(posedge clk);
    #1;

    // Watchdog timeout: 8 cycles in WAIT_D after the handshake
    push_exp(32'd0, 1'b1);
    start_req(1'b0, 32'h0000_7000, 32'h0, 4'hF);
    wait_resp(lat);
    chk("to_latency", 32'(lat), 32'd10);
    @(posedge clk);
    #1 set_d(1'b1, 5'd1, 3'd1, 32'h7777_7777, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("to_late_d_ready", 32'(d_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    set_d(1'b0, 5'd0, 3'd0, 32'd0, 1'b0);

    // Reset while waiting for D
    start_req(1'b0, 32'h0000_8000, 32'h0, 4'hF);
    @(posedge clk);
    #1;
    chk("rst_mid_wait", 32'(d_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_a_valid", 32'(a_valid), 32'd0);
    chk("rst_mid_d_ready", 32'(d_ready), 32'd0);
    chk("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_d(1'b1, 5'd1, 3'd1, 32'hCAFE_F00D, 1'b0);
    push_exp(32'hCAFE_F00D, 1'b0);
    start_req(1'b0, 32'h0000_9000, 32'h0, 4'hF);
    wait_resp(lat);
    chk("post_rst_latency", 32'(lat), 32'd3);
    @(posedge clk);
    #1 set_d(1'b0, 5'd0, 3'd0, 32'd0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_bus_master.md
Name: dcache_bus_master

Overview:
- Upstream master feeding the Dcache SRAM bus handler.
- Converts single-word Dcache miss/writeback requests into TileLink-UL A-channel Get/PutFullData beats.
- Tracks exactly one outstanding transaction, consumes the matching D-channel AccessAck/AccessAckData, and returns data/status to the Dcache controller.
- Includes a response watchdog so a lost response cannot hang the cache.

Parameters:
- SOURCE_ID, 5'b00001, master ID driven on a_source; D beats whose d_source differs are ignored.
- TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT_D before an error response is forced (1..65535).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  cache request present
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 = write (Put), 0 = read (Get)
- req_addr  in  32  word address
- req_wdata  in  32  write data
- req_mask  in  4  byte mask; must be 4'hF
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  read data (0 for writes and errors)
- resp_err  out  1  completion failed
- a_valid  out  1  A beat valid
- a_ready  in  1  A beat accepted
- a_opcode  out  3  0 = PutFullData, 4 = Get
- a_param  out  3  constant 0
- a_size  out  4  constant 2
- a_source  out  5  SOURCE_ID
- a_address  out  32  registered req_addr
- a_mask  out  4  constant 4'hF
- a_data  out  32  registered req_wdata (0 for Get)
- a_corrupt  out  1  constant 0
- d_valid  in  1  D beat valid
- d_ready  out  1  high in WAIT_D only
- d_opcode  in  3  0 = AccessAck, 1 = AccessAckData
- d_source  in  5  responder's echo of master ID
- d_data  in  32  read data
- d_denied  in  1  slave refused access
- d_corrupt  in  1  data corrupted

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0 except req_ready = 1 and the constants.
  - Internal address/data/we registers cleared.
- States: IDLE, SEND_A, WAIT_D, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, capture addr/wdata/we.
  - If req_addr[1:0] != 0 or req_mask != 4'hF: go to RESP with error flag set and issue no bus beat.
  - Otherwise go to SEND_A.
- SEND_A:
  - a_valid = 1; all A fields stay stable until a_valid && a_ready.
  - On handshake: clear the watchdog and go to WAIT_D.
  - A-channel latency from acceptance is at least 1 cycle.
- WAIT_D:
  - d_ready = 1; the watchdog increments every cycle.
  - A beat with d_valid && d_source == SOURCE_ID completes the transaction and goes to RESP.
    - Read: captures d_data.
    - Error when d_denied || d_corrupt, or when d_opcode is not the expected value (1 for Get, 0 for Put).
  - A beat with a mismatched source is accepted (d_ready stays high) and discarded; the block stays in WAIT_D.
  - When the watchdog reaches TIMEOUT_CYCLES with no matching beat, go to RESP with error set.
  - A matching beat in the same cycle as expiry wins: it is treated as a normal completion.
- RESP:
  - resp_valid = 1 for exactly one cycle.
  - resp_err = error flag.
  - resp_rdata = captured data for a successful read, else 0.
  - Next state IDLE; no new request is accepted in this cycle.
- Minimum request-to-resp_valid latency with a_ready and d_valid both tied high: 3 cycles (IDLE → SEND_A → WAIT_D → RESP).
- resp_valid and resp_err are registered outputs.
- Asynchronous reset at any point aborts the transaction and leaves no pending state. Any D beat arriving after reset is ignored, because d_ready = 0 outside WAIT_D.
- Watchdog is a 16-bit counter and saturates; it never wraps.

Decomposition:
- Shared package/define file holds:
  - TileLink opcodes: A_PUTFULL = 0, A_GET = 4, D_ACK = 0, D_ACKDATA = 1.
  - Size constant 2.
  - Source IDs: DCACHE = 5'b00001, ICACHE = 5'b00010.
  - State encodings.
- One natural sub-module, bus_resp_watchdog: counter with clear, enable, saturate, and an expiry flag.

Test Plan:
- Read, ideal bus: req_we = 0, addr 0x0000_1000; a_ready = 1; response d_opcode = 1, d_data = 0xDEAD_BEEF, source 1 → a_opcode 4; resp_valid at cycle +3 with rdata 0xDEAD_BEEF, err 0.
- Write with back-pressure: req_we = 1, addr 0x0000_2004, wdata 0x1234_5678; a_ready low for 4 cycles → A fields stable throughout; a_opcode 0; d_opcode 0 → resp_err 0, rdata 0.
- Foreign source then own: D beat with source 5'b00010, then source 5'b00001 with data 0xA5A5_A5A5 → first beat is dropped; single resp_valid with 0xA5A5_A5A5.
- Error paths:
  - d_denied = 1 → resp_err 1.
  - addr 0x0000_0003 → resp_err 1 with a_valid never asserted.
  - mask 4'h3 → resp_err 1 with no bus beat.
- Timeout: TIMEOUT_CYCLES = 8, no D beat → resp_valid with err 1 exactly 8 cycles after the A handshake. A late D beat is then ignored (d_ready = 0).
- Reset mid-transaction: rst_n low while in WAIT_D → immediately req_ready 1, a_valid 0, d_ready 0, resp_valid 0; a subsequent read completes normally.
